// File: rtl/cache_backing_memory.sv
// cache_backing_memory: fixed-latency single-word memory responder sitting below the cache controller.
// Optional range checking (misaligned / above-index address bits) is enabled by defining MEM_RANGE_CHECK_EN.
module cache_backing_memory #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        mem_ready
`ifdef MEM_RANGE_CHECK_EN
  ,
  output logic        mem_error
`endif
);

  // state | meaning
  // IDLE  | waiting for a request
  // WAIT  | latency countdown on captured request
  // DONE  | completion cycle, mem_ready high
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  localparam int         IW        = $clog2(DEPTH);
  localparam logic [7:0] CNT_INIT  = 8'(LATENCY - 1);
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  state_e          state_q;
  logic [7:0]      cnt_q;
  logic            op_wr_q;
  logic [IW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic            err_q;
  logic            ready_q;
  logic [31:0]     rdata_q;
  logic [31:0]     mem_q [DEPTH];

  logic            req;
  logic [IW-1:0]   req_idx;
  logic            req_err;
  logic            fin_d;
  logic            fin_wr_d;
  logic            fin_err_d;
  logic [IW-1:0]   fin_idx_d;
  logic [31:0]     fin_data_d;

  assign req     = mem_read | mem_write;
  assign req_idx = mem_address[IW+1:2];

`ifdef MEM_RANGE_CHECK_EN
  logic error_q;
  assign req_err   = (mem_address[1:0] != 2'b00) || (mem_address[31:IW+2] != '0);
  assign mem_error = error_q;
`else
  logic addr_unused;
  assign req_err     = 1'b0;
  assign addr_unused = ^{mem_address[31:IW+2], mem_address[1:0]};
`endif

  // With LATENCY==1 the access completes on its acceptance edge, so the live inputs are used.
  always_comb begin
    fin_d      = 1'b0;
    fin_wr_d   = op_wr_q;
    fin_err_d  = err_q;
    fin_idx_d  = idx_q;
    fin_data_d = wdata_q;
    if (state_q == IDLE) begin
      fin_wr_d   = mem_write;
      fin_err_d  = req_err;
      fin_idx_d  = req_idx;
      fin_data_d = mem_write_data;
    end
    if (!reset) begin
      fin_d = ((state_q == WAIT) && (cnt_q == 8'd1)) ||
              ((state_q == IDLE) && req && (LATENCY == 1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
`ifdef MEM_RANGE_CHECK_EN
      error_q <= 1'b0;
`endif
    end else begin
      ready_q <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
      error_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (req) begin
            op_wr_q <= mem_write;
            idx_q   <= req_idx;
            wdata_q <= mem_write_data;
            err_q   <= req_err;
            cnt_q   <= CNT_INIT;
            state_q <= (LATENCY == 1) ? DONE : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (fin_d) begin
        ready_q <= 1'b1;
`ifdef MEM_RANGE_CHECK_EN
        error_q <= fin_err_d;
`endif
        if (!fin_wr_d) rdata_q <= fin_err_d ? ERR_WORD : mem_q[fin_idx_d];
      end
    end
  end

  // Array is never reset; contents survive reset and are unspecified at power-up.
  always_ff @(posedge clk) begin
    if (fin_d && fin_wr_d && !fin_err_d) mem_q[fin_idx_d] <= fin_data_d;
  end

  assign mem_ready     = ready_q;
  assign mem_read_data = rdata_q;

endmodule

// File: tb/tb_cache_backing_memory.sv
// Bench for cache_backing_memory: transaction-window model for a LATENCY=4 instance plus
// directed literal checks, and a LATENCY=1 instance with literal checks.
module tb_cache_backing_memory;

  localparam int DEPTH = 1024;
  localparam int LAT   = 4;
  localparam int IW    = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] mem_address = '0, mem_write_data = '0;
  logic [31:0] mem_read_data;
  logic        mem_ready;
  logic        b_read = 1'b0, b_write = 1'b0;
  logic [31:0] b_address = '0, b_wdata = '0;
  logic [31:0] b_rdata;
  logic        b_ready;
`ifdef MEM_RANGE_CHECK_EN
  logic        mem_error, b_error;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cache_backing_memory #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready)
`ifdef MEM_RANGE_CHECK_EN
    , .mem_error(mem_error)
`endif
  );

  cache_backing_memory #(.DEPTH(DEPTH), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset), .mem_read(b_read), .mem_write(b_write),
    .mem_address(b_address), .mem_write_data(b_wdata),
    .mem_read_data(b_rdata), .mem_ready(b_ready)
`ifdef MEM_RANGE_CHECK_EN
    , .mem_error(b_error)
`endif
  );

  // Model: an access accepted at edge e is ready in the cycle after edge e+LAT-1,
  // and the responder can accept again from edge e+LAT+1 on.
  int          cyc = 0;
  bit          live = 0;
  bit          pend = 0;
  int          comp_e = 0, free_e = 0;
  bit          p_wr, p_err;
  int          p_idx;
  logic [31:0] p_dat;
  logic [31:0] mm [int];
  bit          exp_ready = 0, exp_err = 0, rd_known = 1;
  logic [31:0] exp_rdata = '0;

  function automatic bit addr_err(input logic [31:0] a);
`ifdef MEM_RANGE_CHECK_EN
    logic [31:0] upper;
    upper = a >> (IW + 2);
    return (a[1:0] != 2'b00) || (upper != 0);
`else
    return a[0] & 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    cyc++;
    exp_ready = 0;
    exp_err = 0;
    if (reset) begin
      pend = 0;
      free_e = cyc + 1;
      exp_rdata = '0;
      rd_known = 1;
      live = 1;
    end else if (live) begin
      if (!pend && cyc >= free_e && (mem_read || mem_write)) begin
        pend   = 1;
        p_wr   = mem_write;
        p_idx  = int'(mem_address[IW+1:2]);
        p_dat  = mem_write_data;
        p_err  = addr_err(mem_address);
        comp_e = cyc + LAT - 1;
        free_e = cyc + LAT + 1;
      end
      if (pend && cyc == comp_e) begin
        pend = 0;
        exp_ready = 1;
        exp_err = p_err;
        if (p_wr) begin
          if (!p_err) mm[p_idx] = p_dat;
        end else if (p_err) begin
          exp_rdata = 32'hDEAD_BEEF;
          rd_known = 1;
        end else if (mm.exists(p_idx)) begin
          exp_rdata = mm[p_idx];
          rd_known = 1;
        end else begin
          rd_known = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      n_cmp++;
      if (mem_ready !== exp_ready) begin
        n_err++;
        $display("FAIL model_ready @%0d: got %b expected %b", cyc, mem_ready, exp_ready);
      end
      if (rd_known) begin
        n_cmp++;
        if (mem_read_data !== exp_rdata) begin
          n_err++;
          $display("FAIL model_rdata @%0d: got %h expected %h", cyc, mem_read_data, exp_rdata);
        end
      end
`ifdef MEM_RANGE_CHECK_EN
      n_cmp++;
      if (mem_error !== exp_err) begin
        n_err++;
        $display("FAIL model_error @%0d: got %b expected %b", cyc, mem_error, exp_err);
      end
`endif
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One access on the LATENCY=4 instance; lat counts falling edges from request to ready.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rdat, output logic err);
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_address = a; mem_write_data = d;
    lat = -1; rdat = '0; err = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin mem_read = 1'b0; mem_write = 1'b0; end
      if (mem_ready) begin
        lat = i;
        rdat = mem_read_data;
`ifdef MEM_RANGE_CHECK_EN
        err = mem_error;
`endif
        break;
      end
    end
    if (lat < 0) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic access_b(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rdat);
    @(negedge clk);
    b_read = rd; b_write = wr; b_address = a; b_wdata = d;
    lat = -1; rdat = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin b_read = 1'b0; b_write = 1'b0; end
      if (b_ready) begin lat = i; rdat = b_rdata; break; end
    end
    if (lat < 0) chk("l1_ready_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] tbl_a [4] = '{32'h0000_0000, 32'h0000_0FFC, 32'h0000_0200, 32'h0000_03C8};
  logic [31:0] tbl_d [4] = '{32'h0123_4567, 32'hFFFF_0000, 32'h8000_0001, 32'h5A5A_A5A5};

  initial begin
    int lat, first, second, pulses;
    logic [31:0] rd;
    logic er;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_ready", {31'd0, mem_ready}, 32'd0);
    chk("reset_rdata", mem_read_data, 32'd0);
    chk("reset_l1_ready", {31'd0, b_ready}, 32'd0);

    access(1'b0, 1'b1, 32'h40, 32'hA5A5_0001, lat, rd, er);
    chk("wr_latency", lat, 32'd4);
    access(1'b1, 1'b0, 32'h40, 32'h0, lat, rd, er);
    chk("rd_latency", lat, 32'd4);
    chk("rd_data_40", rd, 32'hA5A5_0001);

    // Reset mid-write: the earlier contents of 0x80 must survive.
    access(1'b0, 1'b1, 32'h80, 32'h1111_2222, lat, rd, er);
    @(negedge clk);
    mem_write = 1'b1; mem_address = 32'h80; mem_write_data = 32'h1234_5678;
    @(negedge clk);
    mem_write = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_ready) pulses++;
    end
    chk("abort_no_ready", pulses, 32'd0);
    access(1'b1, 1'b0, 32'h80, 32'h0, lat, rd, er);
    chk("abort_rd_80", rd, 32'h1111_2222);

    access(1'b1, 1'b1, 32'h10, 32'hCAFE_F00D, lat, rd, er);
    chk("rw_latency", lat, 32'd4);
    chk("rw_rdata_held", rd, 32'h1111_2222);
    access(1'b1, 1'b0, 32'h10, 32'h0, lat, rd, er);
    chk("rw_rd_10", rd, 32'hCAFE_F00D);

    @(negedge clk);
    mem_read = 1'b1; mem_address = 32'h40;
    first = -1; second = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (mem_ready) begin
        if (first < 0) first = i;
        else begin second = i; break; end
      end
    end
    mem_read = 1'b0;
    if (second < 0) chk("b2b_timeout", 32'd0, 32'd1);
    chk("b2b_gap", second - first, LAT + 1);

    for (int i = 0; i < 4; i++) access(1'b0, 1'b1, tbl_a[i], tbl_d[i], lat, rd, er);
    for (int i = 0; i < 4; i++) begin
      access(1'b1, 1'b0, tbl_a[i], 32'h0, lat, rd, er);
      chk($sformatf("tbl_rd_%0d", i), rd, tbl_d[i]);
    end

    access(1'b0, 1'b1, 32'h4, 32'h4444_4444, lat, rd, er);
    access(1'b0, 1'b1, 32'h0000_1004, 32'h7777_0004, lat, rd, er);
`ifdef MEM_RANGE_CHECK_EN
    chk("oor_wr_error", {31'd0, er}, 32'd1);
    access(1'b1, 1'b0, 32'h0000_1004, 32'h0, lat, rd, er);
    chk("oor_rd_error", {31'd0, er}, 32'd1);
    chk("oor_rd_data", rd, 32'hDEAD_BEEF);
    access(1'b1, 1'b0, 32'h4, 32'h0, lat, rd, er);
    chk("oor_word4_kept", rd, 32'h4444_4444);
    chk("ok_rd_no_error", {31'd0, er}, 32'd0);
    access(1'b1, 1'b0, 32'h43, 32'h0, lat, rd, er);
    chk("misalign_error", {31'd0, er}, 32'd1);
    chk("misalign_data", rd, 32'hDEAD_BEEF);
`else
    access(1'b1, 1'b0, 32'h4, 32'h0, lat, rd, er);
    chk("alias_rd_4", rd, 32'h7777_0004);
    access(1'b1, 1'b0, 32'h43, 32'h0, lat, rd, er);
    chk("lowbits_ignored", rd, 32'hA5A5_0001);
`endif

    access_b(1'b0, 1'b1, 32'h8, 32'h5555_AAAA, lat, rd);
    chk("l1_wr_latency", lat, 32'd1);
    access_b(1'b1, 1'b0, 32'h8, 32'h0, lat, rd);
    chk("l1_rd_latency", lat, 32'd1);
    chk("l1_rd_data", rd, 32'h5555_AAAA);
    @(negedge clk);
    b_read = 1'b1; b_address = 32'h8;
    first = -1; second = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (b_ready) begin
        if (first < 0) first = i;
        else begin second = i; break; end
      end
    end
    b_read = 1'b0;
    if (second < 0) chk("l1_b2b_timeout", 32'd0, 32'd1);
    chk("l1_b2b_gap", second - first, 32'd2);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
